// File: rtl/dice_roller_multi.sv
// Electronic dice: N_DICE odometer-chained dice roll while the button is held; sum and strobe on release.
// Optional button debounce is enabled by defining DICE_DEBOUNCE_EN.
module dice_roller_multi #(
   parameter int FACES  = 6,
   parameter int N_DICE = 2,
   parameter int CNT_W  = 8,
`ifdef DICE_DEBOUNCE_EN
   parameter int DEBOUNCE_CYCLES = 4,
`endif
   localparam int DW = $clog2(FACES + 1),
   localparam int SW = $clog2(N_DICE * FACES + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 button,
   output logic [N_DICE*DW-1:0] throw,
   output logic [SW-1:0]        sum,
   output logic                 result_valid,
   output logic                 rolling,
   output logic [CNT_W-1:0]     roll_count
);

   typedef enum logic [1:0] {IDLE, ROLL, DONE} state_t;

   localparam logic [DW-1:0] ONE_V   = DW'(1);
   localparam logic [DW-1:0] FACES_V = DW'(FACES);

   state_t        state_reg;
   logic          sync1_reg;
   logic          btn_s_reg;
   logic          btn_q;
   logic [DW-1:0] die_reg  [N_DICE];
   logic [DW-1:0] die_next [N_DICE];
   logic [SW-1:0] sum_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= 1'b0;
         btn_s_reg <= 1'b0;
      end else begin
         sync1_reg <= button;
         btn_s_reg <= sync1_reg;
      end
   end

`ifdef DICE_DEBOUNCE_EN
   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [DBW-1:0] db_cnt_reg;
   logic           btn_q_reg;

   // Any cycle where the synchronised input agrees with the accepted level restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt_reg <= '0;
         btn_q_reg  <= 1'b0;
      end else if (btn_s_reg == btn_q_reg) begin
         db_cnt_reg <= '0;
      end else if (db_cnt_reg == DBW'(DEBOUNCE_CYCLES - 1)) begin
         db_cnt_reg <= '0;
         btn_q_reg  <= btn_s_reg;
      end else begin
         db_cnt_reg <= db_cnt_reg + DBW'(1);
      end
   end

   assign btn_q = btn_q_reg;
`else
   assign btn_q = btn_s_reg;
`endif

   // Odometer step: a corrupted die snaps back to 1 and swallows any incoming carry.
   always_comb begin
      logic c;
      c        = (state_reg == ROLL);
      sum_next = '0;
      for (int k = 0; k < N_DICE; k++) begin
         die_next[k] = die_reg[k];
         if (die_reg[k] == '0 || die_reg[k] > FACES_V) begin
            die_next[k] = ONE_V;
            c           = 1'b0;
         end else if (c) begin
            if (die_reg[k] == FACES_V) begin
               die_next[k] = ONE_V;
            end else begin
               die_next[k] = die_reg[k] + ONE_V;
               c           = 1'b0;
            end
         end
         sum_next = sum_next + SW'(die_reg[k]);
      end
   end

   generate
      for (genvar gi = 0; gi < N_DICE; gi++) begin : g_throw
         assign throw[gi*DW +: DW] = die_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         rolling      <= 1'b0;
         result_valid <= 1'b0;
         sum          <= SW'(N_DICE);
         roll_count   <= '0;
         for (int k = 0; k < N_DICE; k++) die_reg[k] <= ONE_V;
      end else begin
         result_valid <= 1'b0;
         for (int k = 0; k < N_DICE; k++) die_reg[k] <= die_next[k];
         case (state_reg)
            IDLE: begin
               if (btn_q) begin
                  state_reg <= ROLL;
                  rolling   <= 1'b1;
               end
            end
            ROLL: begin
               if (!btn_q) begin
                  state_reg <= DONE;
                  rolling   <= 1'b0;
               end
            end
            DONE: begin
               sum          <= sum_next;
               result_valid <= 1'b1;
               roll_count   <= roll_count + CNT_W'(1);
               state_reg    <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
               rolling   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dice_roller_multi.sv
// Self-checking bench for dice_roller_multi (FACES=6, N_DICE=2, CNT_W=8, default build).
module tb_dice_roller_multi;

   localparam int FACES  = 6;
   localparam int N_DICE = 2;
   localparam int CNT_W  = 8;
   localparam int DW     = 3;
   localparam int SW     = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 button;
   logic [N_DICE*DW-1:0] throw;
   logic [SW-1:0]        sum;
   logic                 result_valid;
   logic                 rolling;
   logic [CNT_W-1:0]     roll_count;

   always #5 clk = ~clk;

   dice_roller_multi #(.FACES(FACES), .N_DICE(N_DICE), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .button(button), .throw(throw), .sum(sum),
      .result_valid(result_valid), .rolling(rolling), .roll_count(roll_count)
   );

   typedef struct {int d0; int d1; int s; int cnt;} exp_t;
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   m_d0 = 1;
   int   m_d1 = 1;
   int   m_cnt = 0;

   task automatic model_reset();
      m_d0 = 1; m_d1 = 1; m_cnt = 0;
      sb.delete();
   endtask

   task automatic model_advance(input int n);
      for (int i = 0; i < n; i++) begin
         m_d0++;
         if (m_d0 > FACES) begin
            m_d0 = 1;
            m_d1++;
            if (m_d1 > FACES) m_d1 = 1;
         end
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1; button = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // One press of h cycles; expected result pushed at stimulus, popped at the strobe.
   task automatic do_roll(input int h);
      exp_t e;
      int   rc;
      bit   got;
      model_advance(h);
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
      e.d0 = m_d0; e.d1 = m_d1; e.s = m_d0 + m_d1; e.cnt = m_cnt;
      sb.push_back(e);
      rc = 0; got = 1'b0;
      @(negedge clk);
      button = 1'b1;
      for (int t = 1; t <= h + 12 && !got; t++) begin
         @(negedge clk);
         if (t == h) button = 1'b0;
         if (rolling) rc++;
         if (result_valid) begin
            got = 1'b1;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_empty: result_valid with no expected roll");
            end else begin
               e = sb.pop_front();
               $display("roll h=%0d die0=%0d die1=%0d sum=%0d count=%0d", h,
                        throw[2:0], throw[5:3], sum, roll_count);
               if (throw[2:0] !== 3'(e.d0)) begin
                  errors++; $display("FAIL die0: got %0d expected %0d", throw[2:0], e.d0);
               end
               checks++;
               if (throw[5:3] !== 3'(e.d1)) begin
                  errors++; $display("FAIL die1: got %0d expected %0d", throw[5:3], e.d1);
               end
               checks++;
               if (sum !== 4'(e.s)) begin
                  errors++; $display("FAIL sum: got %0d expected %0d", sum, e.s);
               end
               checks++;
               if (roll_count !== 8'(e.cnt)) begin
                  errors++; $display("FAIL roll_count: got %0d expected %0d", roll_count, e.cnt);
               end
            end
         end
      end
      button = 1'b0;
      checks++;
      if (!got) begin
         errors++; $display("FAIL timeout: no result_valid within %0d cycles, expected 1", h + 12);
         sb.delete();
      end
      checks++;
      if (rc != h) begin
         errors++; $display("FAIL rolling_cycles: got %0d expected %0d", rc, h);
      end
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0) begin
         errors++; $display("FAIL pulse_width: result_valid got %b expected 0", result_valid);
      end
   endtask

   task automatic test_reset();
      reset_dut();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (throw !== 6'b001_001) begin
         errors++; $display("FAIL reset_throw: got %b expected 001001", throw);
      end
      checks++;
      if (sum !== 4'd2) begin
         errors++; $display("FAIL reset_sum: got %0d expected 2", sum);
      end
      checks++;
      if (result_valid !== 1'b0 || rolling !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got rv=%b rolling=%b expected 0 0", result_valid, rolling);
      end
      checks++;
      if (roll_count !== 8'd0) begin
         errors++; $display("FAIL reset_count: got %0d expected 0", roll_count);
      end
      rst = 1'b0;
   endtask

   task automatic test_seven();
      reset_dut();
      do_roll(7);
      checks++;
      if (throw !== {3'd2, 3'd2} || sum !== 4'd4 || roll_count !== 8'd1) begin
         errors++;
         $display("FAIL seven: got throw=%b sum=%0d count=%0d expected 010010 4 1", throw, sum, roll_count);
      end
   endtask

   task automatic test_wrap();
      reset_dut();
      do_roll(36);
      checks++;
      if (throw !== {3'd1, 3'd1} || sum !== 4'd2) begin
         errors++; $display("FAIL wrap36: got throw=%b sum=%0d expected 001001 2", throw, sum);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 10; i++) do_roll(int'($urandom_range(1, 15)));
   endtask

   task automatic test_reset_mid_roll();
      bit seen;
      @(negedge clk);
      button = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (rolling !== 1'b1) begin
         errors++; $display("FAIL mid_rolling: got %b expected 1", rolling);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (throw !== 6'b001_001 || sum !== 4'd2 || rolling !== 1'b0 || roll_count !== 8'd0) begin
         errors++;
         $display("FAIL mid_reset: got throw=%b sum=%0d rolling=%b count=%0d expected 001001 2 0 0",
                  throw, sum, rolling, roll_count);
      end
      button = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (result_valid || rolling) seen = 1'b1;
      end
      checks++;
      if (seen || roll_count !== 8'd0) begin
         errors++; $display("FAIL mid_abort: got activity=%b count=%0d expected 0 0", seen, roll_count);
      end
   endtask

   task automatic test_count_wrap();
      reset_dut();
      for (int i = 0; i < 256; i++) do_roll(1);
      checks++;
      if (roll_count !== 8'd0) begin
         errors++; $display("FAIL count_wrap: got %0d expected 0", roll_count);
      end
   endtask

   initial begin
      rst = 1'b1;
      button = 1'b0;
      test_reset();
      test_seven();
      test_wrap();
      test_back_to_back();
      test_reset_mid_roll();
      test_count_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
